// File: rtl/cache_mem_arbiter.sv
// ----------------------------------------------------------------------------
// cache_mem_arbiter
//
// Shares one physical-memory line port between the instruction cache (miss
// fill) and the data cache (miss fill or dirty writeback). One requester is
// granted at a time. Its address, write line and operation are latched on the
// grant edge. The pmem handshake then runs from those latched copies, so the
// granted cache may change its inputs freely while the transfer is in flight.
// The completion is routed back only to the side that owns the grant.
//
// Ports
//   clk, rst                 clock and asynchronous active-high reset
//   i_read, i_addr           icache line read request (held until i_resp)
//   i_rdata, i_resp          icache line data, qualified by a 1-cycle i_resp
//   d_read, d_write, d_addr  dcache line request (held until d_resp)
//   d_wdata                  dcache writeback line
//   d_rdata, d_resp          dcache line data, qualified by a 1-cycle d_resp
//   pmem_read, pmem_write    registered memory strobes (at most one high)
//   pmem_addr, pmem_wdata    latched address / write line of the granted side
//   pmem_rdata, pmem_resp    memory read line and 1-cycle completion pulse
// ----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        HOLD   = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    state_t            state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              read_q, read_d;
    logic              write_q, write_d;

    logic              d_req;
    logic              pick_d;

    // Next-state and grant logic. When both sides request together in IDLE,
    // the side that was not served last wins. last_grant resets to I, so the
    // data cache wins the very first contention after reset.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        read_d       = read_q;
        write_d      = write_q;

        d_req  = d_read | d_write;
        pick_d = d_req & (~i_read | (last_grant_q == GRANT_I));

        unique case (state_q)
            IDLE: begin
                if (pick_d) begin
                    // A simultaneous read+write from the dcache is a writeback;
                    // the write takes priority and no read strobe is issued.
                    state_d = D_BUSY;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    write_d = d_write;
                    read_d  = ~d_write;
                end else if (i_read) begin
                    state_d = I_BUSY;
                    addr_d  = i_addr;
                    read_d  = 1'b1;
                    write_d = 1'b0;
                end
            end

            I_BUSY: begin
                if (pmem_resp) begin
                    state_d      = HOLD;
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    last_grant_d = GRANT_I;
                end
            end

            D_BUSY: begin
                if (pmem_resp) begin
                    state_d      = HOLD;
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    last_grant_d = GRANT_D;
                end
            end

            // One dead cycle so the served cache can drop its request before
            // the arbiter looks at the request lines again.
            HOLD: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // All arbiter state. Reset is asynchronous so the strobes fall the moment
    // rst rises; any memory transaction in flight is simply abandoned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            read_q       <= read_d;
            write_q      <= write_d;
        end
    end

    assign pmem_read  = read_q;
    assign pmem_write = write_q;
    assign pmem_addr  = addr_q;
    assign pmem_wdata = wdata_q;

    // Read data is broadcast to both caches; only the resp pulse qualifies it.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // Responses are combinational from pmem_resp so the cache sees completion
    // in the same cycle. Gating on the busy state discards stray pmem_resp
    // pulses in IDLE/HOLD, and reset drops them at once via state_q.
    assign i_resp = (state_q == I_BUSY) & pmem_resp;
    assign d_resp = (state_q == D_BUSY) & pmem_resp;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cache_mem_arbiter
//
// Directed and randomized transactions against cache_mem_arbiter. The
// reference model works at transaction level: it keeps only which side was
// served last and derives the winner, the expected strobe latency, the latched
// address/op/data and the response routing from the arbitration rules.
// ----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int checks = 0;
    int errors = 0;

    // Model state: 1 when the data cache was the last side served.
    bit model_last_d;

    cache_mem_arbiter #(
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .pmem_read (pmem_read),
        .pmem_write(pmem_write),
        .pmem_addr (pmem_addr),
        .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata),
        .pmem_resp (pmem_resp)
    );

    always #5 clk = ~clk;

    // Hard stop in case the stimulus itself ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                               input logic [LINE_W-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        return $urandom & 32'hFFFF_FFE0;
    endfunction

    task automatic applyStimulus(input bit ir, input bit dr, input bit dw,
                                 input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                                 input logic [LINE_W-1:0] dwd);
        i_read  = ir;
        d_read  = dr;
        d_write = dw;
        i_addr  = ia;
        d_addr  = da;
        d_wdata = dwd;
    endtask

    // Counts rising edges until a memory strobe appears (bounded).
    task automatic wait_strobe(output int cnt);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (pmem_read || pmem_write) break;
        end
    endtask

    // Issues the requested combination and serves every pending side to
    // completion, checking the handshake against the model.
    task automatic run_txn(input bit ir, input bit dr, input bit dw,
                           input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                           input logic [LINE_W-1:0] dwd);
        bit                i_pend;
        bit                d_pend;
        bit                first;
        bit                win_d;
        int                cnt;
        int                hold;
        logic [ADDR_W-1:0] exp_addr;
        logic [LINE_W-1:0] rd;

        i_pend = ir;
        d_pend = dr | dw;
        first  = 1'b1;
        applyStimulus(ir, dr, dw, ia, da, dwd);

        while (i_pend || d_pend) begin
            win_d    = (i_pend && d_pend) ? !model_last_d : d_pend;
            exp_addr = win_d ? da : ia;

            wait_strobe(cnt);
            checkOutput("grant_latency", cnt, first ? 1 : 2);
            checkOutput("pmem_read", pmem_read, win_d ? !dw : 1'b1);
            checkOutput("pmem_write", pmem_write, win_d ? dw : 1'b0);
            checkOutput("pmem_addr", pmem_addr, exp_addr);
            if (win_d && dw) checkOutput("pmem_wdata", pmem_wdata, dwd);

            // The granted cache wiggles its inputs; the latched copies must hold.
            if (win_d) begin
                d_addr  = rand_addr();
                d_wdata = rand_line();
            end else begin
                i_addr = rand_addr();
            end

            hold = $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) begin
                @(posedge clk);
                #1;
                checkOutput("busy_addr_stable", pmem_addr, exp_addr);
                checkOutput("busy_strobe_stable", pmem_read | pmem_write, 1'b1);
                checkOutput("busy_no_resp", i_resp | d_resp, 1'b0);
            end

            rd         = rand_line();
            pmem_rdata = rd;
            pmem_resp  = 1'b1;
            #1;
            checkOutput("i_resp", i_resp, !win_d);
            checkOutput("d_resp", d_resp, win_d);
            checkOutput("resp_rdata", win_d ? d_rdata : i_rdata, rd);

            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            checkOutput("hold_strobes", {pmem_read, pmem_write}, 2'b00);
            checkOutput("hold_resps", {i_resp, d_resp}, 2'b00);

            if (win_d) begin
                d_read  = 1'b0;
                d_write = 1'b0;
                d_pend  = 1'b0;
            end else begin
                i_read = 1'b0;
                i_pend = 1'b0;
            end
            model_last_d = win_d;
            first        = 1'b0;
        end

        // Let HOLD pass so the next call starts from IDLE.
        @(posedge clk);
        #1;
        checkOutput("idle_strobes", {pmem_read, pmem_write}, 2'b00);
    endtask

    initial begin
        int cnt;
        bit ir;
        int op;

        rst        = 1'b1;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        model_last_d = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_pmem_read", pmem_read, 1'b0);
        checkOutput("reset_pmem_write", pmem_write, 1'b0);
        checkOutput("reset_pmem_addr", pmem_addr, '0);
        checkOutput("reset_pmem_wdata", pmem_wdata, '0);
        checkOutput("reset_resps", {i_resp, d_resp}, 2'b00);
        rst = 1'b0;

        // Contention right after reset: D first, then I; then D again.
        run_txn(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_2040, rand_line());
        run_txn(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_2040, rand_line());

        // Single-sided transactions, including a writeback and read+write.
        run_txn(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0, '0);
        run_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_2040, rand_line());
        run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_2040, rand_line());

        // Stray pmem_resp while IDLE is ignored and leaves the arbiter idle.
        pmem_resp = 1'b1;
        #1;
        checkOutput("spurious_resps", {i_resp, d_resp}, 2'b00);
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        checkOutput("spurious_strobes", {pmem_read, pmem_write}, 2'b00);
        run_txn(1'b1, 1'b0, 1'b0, rand_addr(), 32'h0, '0);

        // Randomized mix.
        for (int n = 0; n < 60; n++) begin
            ir = $urandom_range(0, 1);
            op = $urandom_range(0, 3);
            if (!ir && op == 0) ir = 1'b1;
            run_txn(ir, op[0], op[1], rand_addr(), rand_addr(), rand_line());
        end

        // Reset in the middle of an icache fill.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0, '0);
        wait_strobe(cnt);
        checkOutput("pre_reset_latency", cnt, 1);
        #2;
        rst       = 1'b1;
        pmem_resp = 1'b1;
        #1;
        checkOutput("async_reset_read", pmem_read, 1'b0);
        checkOutput("async_reset_addr", pmem_addr, '0);
        checkOutput("async_reset_resps", {i_resp, d_resp}, 2'b00);
        pmem_resp = 1'b0;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        model_last_d = 1'b0;
        run_txn(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0, '0);
        run_txn(1'b1, 1'b1, 1'b0, rand_addr(), rand_addr(), rand_line());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
